// File: rtl/ldh_ctrl.sv
// ldh_ctrl: halfword load controller with sign/zero extension; optional one-word reuse register under WORD_REUSE_EN
module ldh_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_signed,
  input  logic        inv,
  output logic        mem_rd,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;
  state_t state;
  logic   a1;
  logic   sgn;
  function automatic logic [31:0] ext(input logic [31:0] w, input logic hi, input logic s);
    logic [15:0] h;
    h = hi ? w[31:16] : w[15:0];
    return {{16{s & h[15]}}, h};
  endfunction
  assign req_ready = state == IDLE;
`ifdef WORD_REUSE_EN
  logic [29:0] tag;
  logic [31:0] word;
  logic        rv;
  logic        hit;
  assign hit = rv && !inv && tag == req_addr[31:2];
`else
  logic unused_inv;
  assign unused_inv = inv;
`endif
  // request FSM: accept in IDLE, one-cycle read strobe, capture in WAIT, hold response until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      a1        <= 1'b0;
      sgn       <= 1'b0;
`ifdef WORD_REUSE_EN
      tag       <= '0;
      word      <= '0;
      rv        <= 1'b0;
`endif
    end else begin
      mem_rd <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          a1  <= req_addr[1];
          sgn <= req_signed;
          if (req_addr[0]) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
`ifdef WORD_REUSE_EN
          end else if (hit) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= ext(word, req_addr[1], req_signed);
`endif
          end else begin
            state    <= READ;
            mem_rd   <= 1'b1;
            mem_addr <= req_addr[31:2];
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= ext(mem_rdata, a1, sgn);
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
      endcase
`ifdef WORD_REUSE_EN
      if (state == WAIT) begin
        tag  <= mem_addr;
        word <= mem_rdata;
        rv   <= 1'b1;
      end
      if (inv) rv <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_ldh_ctrl.sv
// tb_ldh_ctrl: randomized self-checking bench for ldh_ctrl with a behavioural memory and reuse model
module tb_ldh_ctrl;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_valid = 0;
  logic        req_ready;
  logic [31:0] req_addr = 0;
  logic        req_signed = 0;
  logic        inv = 0;
  logic        mem_rd;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata = 0;
  logic        rsp_valid;
  logic        rsp_ready = 0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  int tests = 0, fails = 0, rd_cnt = 0;
  bit rv = 0;
  logic [29:0] rtag = 0;

  ldh_ctrl dut (.clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_signed(req_signed), .inv(inv), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err));

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [29:0] wa);
    return wa == 30'h40 ? 32'h788EFD0C : {wa[15:0] ^ 16'hA5C3, wa[29:14] + 16'h8001};
  endfunction

  // memory answers one cycle after the strobe; otherwise drives garbage
  always @(posedge clk) begin
    mem_rdata <= mem_rd ? memf(mem_addr) : $urandom;
    if (mem_rd) rd_cnt <= rd_cnt + 1;
  end

  function automatic logic [31:0] exp_data(input logic [31:0] a, input bit s);
    logic [31:0] half;
    if (a[0]) return 0;
    half = (memf(a >> 2) >> (16 * a[1])) & 32'hFFFF;
    if (s && half >= 32'h8000) half = half + 32'hFFFF0000;
    return half;
  endfunction

  task automatic txn(input logic [31:0] a, input bit s, input bit iv, input int hold);
    bit err, hit;
    int lat, rd0, exp_lat, exp_rd;
    logic [31:0] ed;
    err = a[0];
    hit = 0;
`ifdef WORD_REUSE_EN
    hit = !err && rv && rtag == a[31:2] && !iv;
`endif
    exp_lat = (err || hit) ? 1 : 3;
    exp_rd  = (err || hit) ? 0 : 1;
    ed = exp_data(a, s);
    rd0 = rd_cnt;
    req_valid = 1; req_addr = a; req_signed = s; inv = iv;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_valid = 0; inv = 0;
        tests++;
        if (mem_rd !== exp_rd[0] || (exp_rd == 1 && mem_addr !== a[31:2])) begin
          fails++; $display("FAIL strobe a=%h mem_rd=%b mem_addr=%h want %0d/%h", a, mem_rd, mem_addr, exp_rd, a[31:2]);
        end
      end
      if (rsp_valid) lat = i;
    end
    tests++;
    if (lat != exp_lat) begin fails++; $display("FAIL latency a=%h got %0d want %0d", a, lat, exp_lat); end
    tests++;
    if (rsp_data !== ed || rsp_err !== err) begin
      fails++; $display("FAIL data a=%h s=%b got %h/%b want %h/%b", a, s, rsp_data, rsp_err, ed, err);
    end
    tests++;
    if (rd_cnt - rd0 != exp_rd) begin fails++; $display("FAIL rd_count a=%h got %0d want %0d", a, rd_cnt - rd0, exp_rd); end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1 || rsp_data !== ed || rsp_err !== err || req_ready !== 0 || rd_cnt - rd0 != exp_rd) begin
        fails++; $display("FAIL hold a=%h v=%b d=%h e=%b rr=%b want 1/%h/%b/0", a, rsp_valid, rsp_data, rsp_err, req_ready, ed, err);
      end
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    tests++;
    if (rsp_valid !== 0 || req_ready !== 1) begin
      fails++; $display("FAIL release a=%h rsp_valid=%b req_ready=%b want 0/1", a, rsp_valid, req_ready);
    end
`ifdef WORD_REUSE_EN
    if (!err && !hit) begin rv = 1; rtag = a[31:2]; end
`endif
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    tests++;
    if ({req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_err} !== {1'b1, 1'b0, 30'h0, 1'b0, 32'h0, 1'b0}) begin
      fails++; $display("FAIL reset rr=%b rd=%b ma=%h v=%b d=%h e=%b want 1/0/0/0/0/0", req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    rv = 0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    txn(32'h100, 0, 0, 0);
    txn(32'h100, 1, 0, 0);
    txn(32'h102, 1, 0, 0);
    txn(32'h102, 0, 0, 0);
    txn(32'h101, 0, 0, 0);
    txn(32'h103, 1, 0, 1);
  endtask

  task automatic test_stall();
    txn(32'h100, 1, 1, 5);
    txn(32'h101, 1, 0, 5);
  endtask

  task automatic test_back_to_back();
    txn(32'h100, 0, 1, 0);
    txn(32'h102, 0, 0, 0);
    txn(32'h102, 0, 1, 0);
    txn(32'h100, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    req_valid = 1; req_addr = 32'h204; req_signed = 1;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    tests++;
    if ({req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_err} !== {1'b1, 1'b0, 30'h0, 1'b0, 32'h0, 1'b0}) begin
      fails++; $display("FAIL reset_mid rr=%b rd=%b ma=%h v=%b d=%h e=%b want 1/0/0/0/0/0", req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_err);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (rsp_valid !== 0) begin fails++; $display("FAIL stale_rsp rsp_valid=%b want 0", rsp_valid); end
    rst_n = 1;
    rv = 0;
    @(negedge clk);
    txn(32'h206, 1, 0, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      a = 32'h100 + $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) a = $urandom;
      txn(a, 1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ldh_ctrl.md
LDH_CTRL -- requirements
Module: ldh_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  load request present.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-006 req_addr  input  32  byte address of the halfword.
REQ-007 req_signed  input  1  1 = sign-extend, 0 = zero-extend.
REQ-008 inv  input  1  invalidate the reuse word (ignored without WORD_REUSE_EN).
REQ-009 mem_rd  output  1  single-cycle word read strobe.
REQ-010 mem_addr  output  30  word address, req_addr[31:2] of the accepted request.
REQ-011 mem_rdata  input  32  read word, valid exactly one cycle after the mem_rd cycle.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a rising edge.
REQ-014 rsp_data  output  32  extended halfword.
REQ-015 rsp_err  output  1  misaligned request (req_addr[0]=1).

Function
REQ-016 The FSM SHALL have the states IDLE, READ, WAIT and RESP; one request is outstanding at most.
REQ-017 req_ready SHALL be 1 in IDLE only; all other outputs SHALL be registered.
REQ-018 On acceptance, addr and signed SHALL be latched: IDLE->READ when aligned, IDLE->RESP with rsp_err=1 and rsp_data=0 when req_addr[0]=1.
REQ-019 A misaligned request SHALL NOT assert mem_rd.
REQ-020 READ SHALL assert mem_rd=1 for exactly one cycle with mem_addr=latched addr[31:2], then go to WAIT.
REQ-021 WAIT SHALL capture mem_rdata and go to RESP.
REQ-022 Capture selection: addr[1]=0 takes [15:0] and addr[1]=1 takes [31:16]; bits [31:16] of rsp_data are the replicated bit 15 of the half when signed, else zero.
REQ-023 Miss latency: accept at edge T, mem_rd high in cycle T+1, rsp_valid high from cycle T+3.
REQ-024 RESP SHALL hold rsp_valid, rsp_data and rsp_err stable until rsp_ready, then return to IDLE.
REQ-025 A new request SHALL NOT be accepted in the cycle rsp_ready completes a response; minimum request spacing is RESP->IDLE->accept.
REQ-026 mem_addr SHALL hold its last value when mem_rd=0.

Reset
REQ-027 With rst_n=0, the block SHALL immediately drive state=IDLE, req_ready=1, mem_rd=0, mem_addr=0, rsp_valid=0, rsp_data=0 and rsp_err=0, and SHALL clear the reuse valid flag.
REQ-028 Reset mid-operation (READ/WAIT/RESP) SHALL discard the request; mem_rdata arriving after reset SHALL be ignored.

Configuration
REQ-029 Macro WORD_REUSE_EN SHALL enable a one-entry word register: tag (30 bits), word (32 bits), valid flag.
REQ-030 With WORD_REUSE_EN, the word register SHALL be updated in WAIT; an aligned request whose addr[31:2] equals the tag while valid=1 SHALL go IDLE->RESP without mem_rd, with rsp_valid from T+1.
REQ-031 With WORD_REUSE_EN, inv=1 SHALL clear the valid flag at the edge; inv coincident with acceptance SHALL force a miss; error responses SHALL NOT touch the register.
REQ-032 Without WORD_REUSE_EN, every aligned request SHALL take the READ/WAIT path and inv SHALL have no effect.

Verification
REQ-033 mem word 0x788EFD0C, addr 0x100, unsigned -> one mem_rd with mem_addr=0x40, rsp_data=0x0000FD0C, rsp_err=0, rsp_valid at T+3.
REQ-034 Same word, addr 0x100 signed -> 0xFFFFFD0C; addr 0x102 signed -> 0x0000788E; addr 0x102 unsigned -> 0x0000788E.
REQ-035 addr 0x101 -> no mem_rd, rsp_err=1, rsp_data=0, rsp_valid at T+1.
REQ-036 rsp_ready low for 5 cycles -> rsp_valid/rsp_data stable throughout, req_ready=0, no further mem_rd.
REQ-037 WORD_REUSE_EN: 0x100 then 0x102 -> second has no mem_rd and gives 0x0000788E at T+1; after an inv pulse, 0x102 -> mem_rd reissued.
REQ-038 rst_n low during WAIT -> outputs at reset values at once; stale mem_rdata is not presented; next request completes normally.
